boss_motion_ctrl: RTL

//  Parametrised boss movement controller: N-player aggro targeting, gravity-based jump
//  arc, and a ground-charge attack mode. Sits between the game FSM / player blocks and
//  the boss sprite renderer; updates once per frame_tick, outputs sprite top-left coords.

---
 rtl/boss_motion_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/boss_motion_ctrl.sv
// Boss movement controller: aggro-driven targeting, gravity jump arc and ground charge.
// All motion advances on frame_tick while the game is running; outputs are registered.
module boss_motion_ctrl #(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned GROUND_Y    = 524,
    parameter int unsigned START_X     = 768,
    parameter int unsigned X_MIN       = 128,
    parameter int unsigned X_MAX       = 896,
    parameter int unsigned JUMP_V0     = 18,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned VFALL_MAX   = 12,
    parameter int unsigned MOVE_STEP   = 5,
    parameter int unsigned CHARGE_STEP = 10,
    parameter int unsigned CHARGE_LEN  = 40,
    parameter int unsigned WAIT_TICKS  = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic [1:0]                game_active,
    input  logic [12*N_PLAYERS-1:0]   player_x,
    input  logic [4*N_PLAYERS-1:0]    player_aggro,
    input  logic                      mode_sel,
    input  logic                      enraged,
    output logic [11:0]               boss_x,
    output logic [11:0]               boss_y,
    output logic                      airborne,
    output logic                      facing_left,
    output logic                      land_pulse
);

    localparam int unsigned WaitW   = $clog2(WAIT_TICKS + 2);
    localparam int unsigned ChargeW = $clog2(CHARGE_LEN + 2);

    localparam logic [11:0]        StartX     = 12'(START_X);
    localparam logic [11:0]        GroundY    = 12'(GROUND_Y);
    localparam logic [11:0]        XMin       = 12'(X_MIN);
    localparam logic [11:0]        XMax       = 12'(X_MAX);
    localparam logic [11:0]        MoveStep   = 12'(MOVE_STEP);
    localparam logic [11:0]        ChargeStep = 12'(CHARGE_STEP);
    localparam logic [5:0]         JumpV0     = 6'(JUMP_V0);
    localparam logic [5:0]         Gravity    = 6'(GRAVITY);
    localparam logic [5:0]         VFallMax   = 6'(VFALL_MAX);
    localparam logic [WaitW-1:0]   WaitFull   = WaitW'(WAIT_TICKS);
    localparam logic [WaitW-1:0]   WaitHalf   = WaitW'(WAIT_TICKS >> 1);
    localparam logic [ChargeW-1:0] ChargeLen  = ChargeW'(CHARGE_LEN);

    typedef enum logic [1:0] {StWait, StRise, StFall, StCharge} state_e;

    state_e               state_q, state_d;
    logic [11:0]          x_q, x_d;
    logic [11:0]          y_q, y_d;
    logic [5:0]           vy_q, vy_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [ChargeW-1:0]   charge_q, charge_d;
    logic                 dir_q, dir_d;
    logic                 face_q, face_d;
    logic                 land_q, land_d;

    // Clamped horizontal step: never crosses X_MIN/X_MAX, never wraps.
    function automatic logic [11:0] step_x(input logic [11:0] x, input logic left,
                                           input logic [11:0] step);
        logic [12:0] sum;
        sum = {1'b0, x} + {1'b0, step};
        if (left) begin
            if ({1'b0, x} >= ({1'b0, XMin} + {1'b0, step})) step_x = x - step;
            else                                              step_x = XMin;
        end else begin
            if (sum <= {1'b0, XMax}) step_x = sum[11:0];
            else                     step_x = XMax;
        end
    endfunction

    // Highest aggro wins; strict compare keeps the lowest index on ties.
    logic [3:0]  best_aggro;
    logic [11:0] target_x;
    logic        dir_left;

    always_comb begin
        best_aggro = player_aggro[3:0];
        target_x   = player_x[11:0];
        for (int i = 1; i < int'(N_PLAYERS); i++) begin
            if (player_aggro[4*i +: 4] > best_aggro) begin
                best_aggro = player_aggro[4*i +: 4];
                target_x   = player_x[12*i +: 12];
            end
        end
    end

    assign dir_left = (target_x < x_q);

    logic [11:0]      move_x;
    logic [11:0]      charge_x;
    logic [6:0]       vy_inc;
    logic [5:0]       vy_fall;
    logic [12:0]      y_fall;
    logic [WaitW-1:0] wait_load;

    assign move_x    = step_x(x_q, dir_q, MoveStep);
    assign charge_x  = step_x(x_q, dir_q, ChargeStep);
    assign vy_inc    = {1'b0, vy_q} + {1'b0, Gravity};
    assign vy_fall   = (vy_inc > {1'b0, VFallMax}) ? VFallMax : vy_inc[5:0];
    assign y_fall    = {1'b0, y_q} + {7'b0, vy_fall};
    assign wait_load = enraged ? WaitHalf : WaitFull;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        wait_d   = wait_q;
        charge_d = charge_q;
        dir_d    = dir_q;
        face_d   = face_q;
        land_d   = 1'b0;

        if (game_active == 2'd0) begin
            state_d  = StWait;
            x_d      = StartX;
            y_d      = GroundY;
            vy_d     = '0;
            wait_d   = '0;
            charge_d = '0;
            dir_d    = 1'b1;
            face_d   = 1'b1;
        end else if (game_active == 2'd1 && frame_tick) begin
            unique case (state_q)
                StWait: begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - 1'b1;
                    end else begin
                        dir_d  = dir_left;
                        face_d = dir_left;
                        if (mode_sel) begin
                            state_d  = StCharge;
                            charge_d = ChargeLen;
                        end else begin
                            state_d = StRise;
                            vy_d    = JumpV0;
                        end
                    end
                end
                StRise: begin
                    x_d = move_x;
                    if (y_q < {6'b0, vy_q}) begin
                        y_d     = '0;
                        vy_d    = '0;
                        state_d = StFall;
                    end else begin
                        y_d = y_q - {6'b0, vy_q};
                        // Post-decrement vy <= GRAVITY is the apex.
                        if ({1'b0, vy_q} <= ({1'b0, Gravity} << 1)) begin
                            vy_d    = '0;
                            state_d = StFall;
                        end else begin
                            vy_d = vy_q - Gravity;
                        end
                    end
                end
                StFall: begin
                    x_d = move_x;
                    if (y_fall >= {1'b0, GroundY}) begin
                        y_d     = GroundY;
                        vy_d    = '0;
                        land_d  = 1'b1;
                        wait_d  = wait_load;
                        state_d = StWait;
                    end else begin
                        y_d  = y_fall[11:0];
                        vy_d = vy_fall;
                    end
                end
                StCharge: begin
                    x_d      = charge_x;
                    charge_d = (charge_q != '0) ? charge_q - 1'b1 : '0;
                    if (charge_q <= ChargeW'(1) || charge_x == XMin || charge_x == XMax) begin
                        land_d  = 1'b1;
                        wait_d  = wait_load;
                        state_d = StWait;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StWait;
            x_q      <= StartX;
            y_q      <= GroundY;
            vy_q     <= '0;
            wait_q   <= '0;
            charge_q <= '0;
            dir_q    <= 1'b1;
            face_q   <= 1'b1;
            land_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            wait_q   <= wait_d;
            charge_q <= charge_d;
            dir_q    <= dir_d;
            face_q   <= face_d;
            land_q   <= land_d;
        end
    end

    assign boss_x      = x_q;
    assign boss_y      = y_q;
    assign airborne    = (state_q == StRise) || (state_q == StFall);
    assign facing_left = face_q;
    assign land_pulse  = land_q;

endmodule
